// File: rtl/fcs_mpc_pkg.sv
// Shared FSM encoding, parameter defaults and the cost-width rule for the FCS-MPC controller.
// Holds no logic and has no flow control.
package fcs_mpc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PREDICT = 2'd1,
    COST    = 2'd2,
    DECIDE  = 2'd3
  } state_t;

  localparam int W_DEF         = 8;
  localparam int FRAC_DEF      = 6;
  localparam int KA_DEF        = 16;
  localparam int KB_DEF        = 16;
  localparam int KC_DEF        = 16;
  localparam int KD_DEF        = 1;
  localparam int WI_DEF        = 1;
  localparam int WV_DEF        = 1;
  localparam int MIN_DWELL_DEF = 2;

  // A 4-bit weight times a W-bit error, plus a second such term, fits in W+5 bits.
  localparam int COST_EXTRA = 5;
  localparam int COST_W_DEF = W_DEF + COST_EXTRA;

  function automatic int cost_width(input int w);
    return w + COST_EXTRA;
  endfunction

endpackage

// File: rtl/fcs_mpc_predict.sv
// One-step current/voltage prediction for a single switch state s, saturated to [0, 2^W-1].
// Purely combinational (0 cycles); no flow control.
module fcs_mpc_predict #(
  parameter int W    = fcs_mpc_pkg::W_DEF,
  parameter int FRAC = fcs_mpc_pkg::FRAC_DEF,
  parameter int KA   = fcs_mpc_pkg::KA_DEF,
  parameter int KB   = fcs_mpc_pkg::KB_DEF,
  parameter int KC   = fcs_mpc_pkg::KC_DEF,
  parameter int KD   = fcs_mpc_pkg::KD_DEF
) (
  input  logic         s,
  input  logic [W-1:0] il,
  input  logic [W-1:0] vg,
  input  logic [W-1:0] vc,
  output logic [W-1:0] p_i,
  output logic [W-1:0] p_v
);

  localparam int PW = 2*W + 2;
  localparam int SW = PW + 1;

  localparam logic [PW-1:0] KA_X = PW'(KA);
  localparam logic [PW-1:0] KB_X = PW'(KB);
  localparam logic [PW-1:0] KC_X = PW'(KC);
  localparam logic [PW-1:0] KD_X = PW'(KD);

  logic signed [PW-1:0] ka_vg, kb_vc, kc_il, kd_vc, di, dv;

  assign ka_vg = signed'(KA_X * PW'(vg));
  assign kb_vc = signed'(KB_X * PW'(vc));
  assign kc_il = signed'(KC_X * PW'(il));
  assign kd_vc = signed'(KD_X * PW'(vc));

  assign di = ka_vg - (s ? '0 : kb_vc);
  assign dv = (s ? '0 : kc_il) - kd_vc;

  // One extra bit above the product width keeps base + shifted delta from wrapping before the clamp.
  function automatic logic [W-1:0] sat_add(input logic [W-1:0] base, input logic signed [PW-1:0] d);
    logic signed [PW-1:0] sh;
    logic signed [SW-1:0] sum;
    sh  = d >>> FRAC;
    sum = signed'({1'b0, PW'(base)}) + signed'({sh[PW-1], sh});
    if (sum[SW-1])
      return '0;
    else if (|sum[SW-2:W])
      return '1;
    else
      return sum[W-1:0];
  endfunction

  assign p_i = sat_add(il, di);
  assign p_v = sat_add(vc, dv);

endmodule

// File: rtl/fcs_mpc_param.sv
// FCS-MPC switch selector: u/u_valid/cost_min appear 4 cycles after the cycle a sample is presented.
// One sample in flight; samples arriving while busy are dropped and set the sticky overrun flag.
module fcs_mpc_param
  import fcs_mpc_pkg::*;
#(
  parameter int W         = W_DEF,
  parameter int FRAC      = FRAC_DEF,
  parameter int KA        = KA_DEF,
  parameter int KB        = KB_DEF,
  parameter int KC        = KC_DEF,
  parameter int KD        = KD_DEF,
  parameter int WI        = WI_DEF,
  parameter int WV        = WV_DEF,
  parameter int MIN_DWELL = MIN_DWELL_DEF
) (
  input  logic                     wb_clk_i,
  input  logic                     wb_rst_i,
  input  logic                     sample_valid,
  input  logic [W-1:0]             iL,
  input  logic [W-1:0]             vg,
  input  logic [W-1:0]             vc,
  input  logic [W-1:0]             iL_ref,
  input  logic [W-1:0]             vc_ref,
  output logic                     u,
  output logic                     u_valid,
  output logic [cost_width(W)-1:0] cost_min,
  output logic                     busy,
  output logic                     overrun
);

  localparam int CW = cost_width(W);
  localparam logic [CW-1:0] WI_X = CW'(WI);
  localparam logic [CW-1:0] WV_X = CW'(WV);
  localparam logic [3:0]    MD   = 4'(MIN_DWELL);

  state_t state, nstate;

  logic [W-1:0]  il_q, vg_q, vc_q, ilr_q, vcr_q;
  logic [W-1:0]  pi0, pi1, pv0, pv1;
  logic [W-1:0]  pi0_q, pi1_q, pv0_q, pv1_q;
  logic [CW-1:0] j0_q, j1_q;
  logic [3:0]    dwell_q, dwell_nxt;
  logic          u_nxt;
  logic [CW-1:0] cost_nxt;

  fcs_mpc_predict #(.W(W), .FRAC(FRAC), .KA(KA), .KB(KB), .KC(KC), .KD(KD)) u_pred0 (
    .s(1'b0), .il(il_q), .vg(vg_q), .vc(vc_q), .p_i(pi0), .p_v(pv0)
  );

  fcs_mpc_predict #(.W(W), .FRAC(FRAC), .KA(KA), .KB(KB), .KC(KC), .KD(KD)) u_pred1 (
    .s(1'b1), .il(il_q), .vg(vg_q), .vc(vc_q), .p_i(pi1), .p_v(pv1)
  );

  function automatic logic [CW-1:0] cost_of(input logic [W-1:0] ir, input logic [W-1:0] pi,
                                            input logic [W-1:0] vr, input logic [W-1:0] pv);
    logic [CW-1:0] ei, ev;
    ei = CW'((ir >= pi) ? ir - pi : pi - ir);
    ev = CW'((vr >= pv) ? vr - pv : pv - vr);
    return WI_X * ei + WV_X * ev;
  endfunction

  always_comb begin
    nstate = state;
    case (state)
      IDLE:    if (sample_valid) nstate = PREDICT;
      PREDICT: nstate = COST;
      COST:    nstate = DECIDE;
      DECIDE:  nstate = IDLE;
      default: nstate = IDLE;
    endcase
  end

  // Switch only once the dwell has expired and the costs strictly disagree; ties keep u.
  always_comb begin
    u_nxt     = u;
    dwell_nxt = dwell_q;
    if (dwell_q >= MD && j0_q != j1_q)
      u_nxt = (j1_q < j0_q);
    if (u_nxt != u)
      dwell_nxt = 4'd1;
    else if (dwell_q < MD)
      dwell_nxt = dwell_q + 4'd1;
    cost_nxt = u_nxt ? j1_q : j0_q;
  end

  assign busy = (state != IDLE);

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state    <= IDLE;
      u        <= 1'b0;
      u_valid  <= 1'b0;
      cost_min <= '0;
      overrun  <= 1'b0;
      dwell_q  <= MD;
      il_q     <= '0;
      vg_q     <= '0;
      vc_q     <= '0;
      ilr_q    <= '0;
      vcr_q    <= '0;
      pi0_q    <= '0;
      pi1_q    <= '0;
      pv0_q    <= '0;
      pv1_q    <= '0;
      j0_q     <= '0;
      j1_q     <= '0;
    end else begin
      state   <= nstate;
      u_valid <= 1'b0;
      if (sample_valid && state != IDLE)
        overrun <= 1'b1;
      case (state)
        IDLE: begin
          if (sample_valid) begin
            il_q  <= iL;
            vg_q  <= vg;
            vc_q  <= vc;
            ilr_q <= iL_ref;
            vcr_q <= vc_ref;
          end
        end
        PREDICT: begin
          pi0_q <= pi0;
          pi1_q <= pi1;
          pv0_q <= pv0;
          pv1_q <= pv1;
        end
        COST: begin
          j0_q <= cost_of(ilr_q, pi0_q, vcr_q, pv0_q);
          j1_q <= cost_of(ilr_q, pi1_q, vcr_q, pv1_q);
        end
        DECIDE: begin
          u        <= u_nxt;
          dwell_q  <= dwell_nxt;
          cost_min <= cost_nxt;
          u_valid  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fcs_mpc_param.sv
// Scoreboard bench for fcs_mpc_param: expected decisions queued at drive time, compared on u_valid.
module tb_fcs_mpc_param;
  import fcs_mpc_pkg::*;

  localparam int W = 8, FRAC = 6, KA = 16, KB = 16, KC = 16, KD = 1, WI = 1, WV = 1;
  localparam int MIN_DWELL = 2;
  localparam int CW = W + 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          sample_valid = 1'b0;
  logic [W-1:0]  il = '0, vg = '0, vc = '0, ilr = '0, vcr = '0;
  logic          u, u_valid, busy, overrun;
  logic [CW-1:0] cost_min;
  logic          ku, ku_valid, kbusy, kovr;
  logic [CW-1:0] kcost;

  always #5 clk = ~clk;

  fcs_mpc_param dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .sample_valid(sample_valid),
    .iL(il), .vg(vg), .vc(vc), .iL_ref(ilr), .vc_ref(vcr),
    .u(u), .u_valid(u_valid), .cost_min(cost_min), .busy(busy), .overrun(overrun)
  );

  fcs_mpc_param #(.KD(64)) dut_kd (
    .wb_clk_i(clk), .wb_rst_i(rst), .sample_valid(sample_valid),
    .iL(il), .vg(vg), .vc(vc), .iL_ref(ilr), .vc_ref(vcr),
    .u(ku), .u_valid(ku_valid), .cost_min(kcost), .busy(kbusy), .overrun(kovr)
  );

  typedef struct {
    int u;
    int cost;
    int cyc;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  int   m_u = 0;
  int   m_dwell = MIN_DWELL;
  int   kd_armed = 0;
  int   kd_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic int sat(input int x);
    if (x < 0) return 0;
    if (x > 255) return 255;
    return x;
  endfunction

  function automatic int iabs(input int x);
    return (x < 0) ? -x : x;
  endfunction

  // Reference model of one decision, advancing the bench's own u/dwell state.
  task automatic model(input int a, input int b, input int c, input int r_i, input int r_v,
                       output int eu, output int ecost);
    int pi0, pi1, pv0, pv1, j0, j1, nu;
    pi1 = sat(a + ((KA*b) >>> FRAC));
    pi0 = sat(a + ((KA*b - KB*c) >>> FRAC));
    pv1 = sat(c + ((0 - KD*c) >>> FRAC));
    pv0 = sat(c + ((KC*a - KD*c) >>> FRAC));
    j1  = WI*iabs(r_i - pi1) + WV*iabs(r_v - pv1);
    j0  = WI*iabs(r_i - pi0) + WV*iabs(r_v - pv0);
    nu  = m_u;
    if (m_dwell >= MIN_DWELL && j0 != j1) nu = (j1 < j0) ? 1 : 0;
    if (nu != m_u) m_dwell = 1;
    else if (m_dwell < MIN_DWELL) m_dwell++;
    m_u   = nu;
    eu    = nu;
    ecost = nu ? j1 : j0;
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input int a, input int b, input int c, input int r_i, input int r_v,
                       input bit push);
    int eu, ec;
    il = 8'(a); vg = 8'(b); vc = 8'(c); ilr = 8'(r_i); vcr = 8'(r_v);
    sample_valid = 1'b1;
    if (push) begin
      model(a, b, c, r_i, r_v, eu, ec);
      q.push_back('{u: eu, cost: ec, cyc: cyc});
    end
    step(1);
    sample_valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 40; i++)
      if (q.size() != 0) step(1);
    step(2);
    check("drain_queue_empty", q.size(), 0);
  endtask

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && u_valid) begin
      if (q.size() == 0) begin
        check("spurious_u_valid", 32'(u_valid), 0);
      end else begin
        e = q.pop_front();
        check("u", 32'(u), e.u);
        check("cost_min", 32'(cost_min), e.cost);
        check("latency", cyc - e.cyc, 4);
      end
    end
    if (!rst && ku_valid && kd_armed != 0) begin
      check("kd64_pv_clamp_cost", 32'(kcost), 10);
      kd_armed = 0;
      kd_seen++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    step(3);
    check("rst_u", 32'(u), 0);
    check("rst_u_valid", 32'(u_valid), 0);
    check("rst_cost_min", 32'(cost_min), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_overrun", 32'(overrun), 0);
    rst = 1'b0;
    step(1);

    // Tie from u=0: both states predict identical values, u stays 0.
    drive(2, 64, 0, 30, 5, 1);
    drain();

    // Nominal, then two samples favouring u=0, fed back-to-back in the u_valid cycle.
    drive(100, 64, 128, 200, 128, 1);
    step(3);
    drive(100, 64, 128, 84, 151, 1);
    step(3);
    drive(100, 64, 128, 84, 151, 1);
    drain();

    // pI saturation at full scale.
    drive(255, 255, 0, 255, 0, 1);
    drain();
    drive(255, 255, 0, 255, 0, 1);
    drain();

    // Lower clamp; the KD=64 instance has pV landing on 0 for both states.
    kd_armed = 1;
    drive(0, 0, 255, 0, 10, 1);
    drain();
    check("kd64_result_seen", kd_seen, 1);

    // Overrun: two samples arrive while busy and must be dropped.
    check("overrun_before", 32'(overrun), 0);
    drive(50, 100, 90, 60, 100, 1);
    check("busy_in_predict", 32'(busy), 1);
    drive(200, 10, 10, 0, 0, 0);
    check("busy_in_cost", 32'(busy), 1);
    drive(7, 200, 3, 255, 255, 0);
    drain();
    check("overrun_set", 32'(overrun), 1);
    check("busy_after_drain", 32'(busy), 0);

    // Reset while in COST aborts the sample.
    drive(100, 64, 128, 200, 128, 0);
    step(1);
    rst = 1'b1;
    step(1);
    check("midrst_u", 32'(u), 0);
    check("midrst_overrun", 32'(overrun), 0);
    check("midrst_busy", 32'(busy), 0);
    rst = 1'b0;
    m_u = 0;
    m_dwell = MIN_DWELL;
    step(4);
    drive(100, 64, 128, 200, 128, 1);
    drain();

    // Random back-to-back traffic.
    for (int i = 0; i < 24; i++) begin
      drive($urandom_range(0, 255), $urandom_range(0, 255), $urandom_range(0, 255),
            $urandom_range(0, 255), $urandom_range(0, 255), 1);
      step(3);
    end
    drain();
    check("overrun_unchanged", 32'(overrun), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
